// File: rtl/stream_data_builder_if.sv
// Port bundle for stream_data_builder: core result stream in, send-FIFO write port and completion status out.
// The block itself connects through the slave modport; the producer/consumer side uses master.
interface stream_data_builder_if #(
    parameter int CORES = 4
);
    localparam int CW = (CORES > 1) ? $clog2(CORES) : 1;

    logic           src_valid;
    logic           src_sop;
    logic           src_eop;
    logic [511:0]   src_data;
    logic [CW-1:0]  src_core_id;
    logic [31:0]    src_data_id;
    logic           src_ready;

    logic           send_fifo_wrreq;
    logic [511:0]   send_fifo_data;
    logic [10:0]    send_fifo_wrusedw;

    logic           done_valid;
    logic [CW-1:0]  done_core_id;
    logic           overflow_err;

    modport master (
        output src_valid, src_sop, src_eop, src_data, src_core_id, src_data_id,
        input  src_ready,
        input  send_fifo_wrreq, send_fifo_data,
        output send_fifo_wrusedw,
        input  done_valid, done_core_id, overflow_err
    );

    modport slave (
        input  src_valid, src_sop, src_eop, src_data, src_core_id, src_data_id,
        output src_ready,
        output send_fifo_wrreq, send_fifo_data,
        input  send_fifo_wrusedw,
        output done_valid, done_core_id, overflow_err
    );
endinterface

// File: rtl/stream_data_builder.sv
// Buffers one core result packet, then writes header + payload to the send FIFO; header lands 2 cycles after eop, payload back-to-back.
// Backpressure: src_ready drops from eop until done; emission waits until the send FIFO can absorb the whole packet.
module stream_data_builder #(
    parameter int CORES = 4,
    parameter int DEPTH = 64
) (
    input  logic                  clk,
    input  logic                  reset_n,
    stream_data_builder_if.slave  bus
);
    localparam int CW   = (CORES > 1) ? $clog2(CORES) : 1;
    localparam int AW   = $clog2(DEPTH);
    localparam int CNTW = AW + 1;

    localparam logic [2:0] S_IDLE       = 3'd0;
    localparam logic [2:0] S_COLLECT    = 3'd1;
    localparam logic [2:0] S_WAIT_SPACE = 3'd2;
    localparam logic [2:0] S_HEADER     = 3'd3;
    localparam logic [2:0] S_DRAIN      = 3'd4;
    localparam logic [2:0] S_DONE       = 3'd5;

    typedef struct packed {
        logic [439:0] rsvd;
        logic [7:0]   core_id;
        logic [31:0]  data_id;
        logic [31:0]  len;
    } hdr_t;

    logic [2:0]      r_state;
    logic [CNTW-1:0] r_count;
    logic [CNTW-1:0] r_rd_idx;
    logic [CW-1:0]   r_core_id;
    logic [31:0]     r_data_id;
    logic            r_wrreq;
    logic [511:0]    r_fifo_dat;
    logic            r_done_vld;
    logic [CW-1:0]   r_done_core;
    logic            r_ovf;
    logic [511:0]    r_mem [DEPTH];

    logic            w_rdy;
    logic            w_accept;
    logic            w_full;
    logic            w_mem_we;
    logic [AW-1:0]   w_wr_idx;
    logic [AW-1:0]   w_rd_addr;
    logic [11:0]     w_space;
    logic [11:0]     w_need;
    logic            w_space_ok;
    hdr_t            w_hdr;

    // Gating with reset_n keeps src_ready low while reset is held yet high on the first cycle after release.
    assign w_rdy      = reset_n && ((r_state == S_IDLE) || (r_state == S_COLLECT));
    assign w_accept   = bus.src_valid && w_rdy;
    assign w_full     = (r_count == CNTW'(DEPTH));
    assign w_wr_idx   = bus.src_sop ? '0 : r_count[AW-1:0];
    assign w_mem_we   = w_accept && (bus.src_sop || ((r_state == S_COLLECT) && !w_full));
    assign w_rd_addr  = r_rd_idx[AW-1:0];
    assign w_space    = {1'b0, 11'd2047 - bus.send_fifo_wrusedw};
    assign w_need     = 12'(r_count) + 12'd1;
    assign w_space_ok = (w_space >= w_need);

    always_comb begin
        w_hdr         = '0;
        w_hdr.len     = 32'(r_count) + 32'd1;
        w_hdr.data_id = r_data_id;
        w_hdr.core_id = 8'(r_core_id);
    end

    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[w_wr_idx] <= bus.src_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_count     <= '0;
            r_rd_idx    <= '0;
            r_core_id   <= '0;
            r_data_id   <= '0;
            r_wrreq     <= 1'b0;
            r_fifo_dat  <= '0;
            r_done_vld  <= 1'b0;
            r_done_core <= '0;
            r_ovf       <= 1'b0;
        end else begin
            r_done_vld <= 1'b0;
            case (r_state)
                S_IDLE, S_COLLECT: begin
                    if (w_accept) begin
                        if (bus.src_sop) begin
                            // sop always (re)starts a packet, discarding anything partially collected.
                            r_count   <= CNTW'(1);
                            r_core_id <= bus.src_core_id;
                            r_data_id <= bus.src_data_id;
                            r_state   <= bus.src_eop ? S_WAIT_SPACE : S_COLLECT;
                        end else if (r_state == S_COLLECT) begin
                            if (w_full) begin
                                r_ovf   <= 1'b1;
                                r_count <= '0;
                                r_state <= S_IDLE;
                            end else begin
                                r_count <= r_count + CNTW'(1);
                                if (bus.src_eop) begin
                                    r_state <= S_WAIT_SPACE;
                                end
                            end
                        end
                    end
                end
                S_WAIT_SPACE: begin
                    if (w_space_ok) begin
                        r_wrreq    <= 1'b1;
                        r_fifo_dat <= w_hdr;
                        r_rd_idx   <= '0;
                        r_state    <= S_HEADER;
                    end
                end
                S_HEADER: begin
                    r_fifo_dat <= r_mem[w_rd_addr];
                    r_rd_idx   <= r_rd_idx + CNTW'(1);
                    r_state    <= S_DRAIN;
                end
                S_DRAIN: begin
                    // r_rd_idx names the next beat to present; reaching count means the last one is on the bus now.
                    if (r_rd_idx == r_count) begin
                        r_wrreq     <= 1'b0;
                        r_fifo_dat  <= '0;
                        r_done_vld  <= 1'b1;
                        r_done_core <= r_core_id;
                        r_state     <= S_DONE;
                    end else begin
                        r_fifo_dat <= r_mem[w_rd_addr];
                        r_rd_idx   <= r_rd_idx + CNTW'(1);
                    end
                end
                S_DONE: begin
                    r_count <= '0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.src_ready       = w_rdy;
    assign bus.send_fifo_wrreq = r_wrreq;
    assign bus.send_fifo_data  = r_fifo_dat;
    assign bus.done_valid      = r_done_vld;
    assign bus.done_core_id    = r_done_core;
    assign bus.overflow_err    = r_ovf;
endmodule

// File: tb/tb_stream_data_builder.sv
// Directed bench for stream_data_builder: packet framing, FIFO-space gating, overflow, restart and async reset.
module tb_stream_data_builder;
    localparam int CORES = 4;
    localparam int DEPTH = 8;

    logic clk = 1'b0;
    logic reset_n;
    int cyc = 0;
    int n_chk = 0;
    int n_pass = 0;
    int acc_cyc = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    logic [1:0] done_core = '0;
    logic [511:0] cap_q[$];
    int capc_q[$];

    stream_data_builder_if #(.CORES(CORES)) ifc ();

    stream_data_builder #(.CORES(CORES), .DEPTH(DEPTH)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (ifc)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Each word is stamped with the clock edge on which the FIFO captures it.
    always @(negedge clk) begin
        if (ifc.send_fifo_wrreq === 1'b1) begin
            cap_q.push_back(ifc.send_fifo_data);
            capc_q.push_back(cyc + 1);
        end
        if (ifc.done_valid === 1'b1) begin
            done_cnt  <= done_cnt + 1;
            done_cyc  <= cyc + 1;
            done_core <= ifc.done_core_id;
        end
    end

    function automatic logic [511:0] pat(input int b);
        logic [511:0] r;
        for (int i = 0; i < 16; i++) r[i*32 +: 32] = 32'(b * 16 + i);
        return r;
    endfunction

    function automatic logic [511:0] hdr(input int len, input logic [31:0] id, input logic [1:0] core);
        logic [511:0] r;
        r = '0;
        r[31:0]  = 32'(len);
        r[63:32] = id;
        r[71:64] = {6'd0, core};
        return r;
    endfunction

    function automatic logic [511:0] cap_at(input int i);
        if (i < cap_q.size()) return cap_q[i];
        return '0;
    endfunction

    function automatic int capc_at(input int i);
        if (i < capc_q.size()) return capc_q[i];
        return -1;
    endfunction

    // Called at a negedge; returns at the negedge after the beat was accepted.
    task automatic send_beat(input logic sop, input logic eop, input logic [511:0] d,
                             input logic [1:0] core, input logic [31:0] id);
        int n;
        n = 0;
        while (ifc.src_ready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            n_chk++;
            $display("FAIL send_beat_ready: src_ready=%b after 200 cycles, required 1", ifc.src_ready);
        end
        ifc.src_valid   = 1'b1;
        ifc.src_sop     = sop;
        ifc.src_eop     = eop;
        ifc.src_data    = d;
        ifc.src_core_id = core;
        ifc.src_data_id = id;
        acc_cyc = cyc + 1;
        @(negedge clk);
        ifc.src_valid = 1'b0;
        ifc.src_sop   = 1'b0;
        ifc.src_eop   = 1'b0;
    endtask

    task automatic wait_done(input int d0, output bit ok);
        int n;
        n = 0;
        while (done_cnt == d0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        ok = (done_cnt != d0);
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        n_chk++; if (ifc.src_ready !== 1'b0) $display("FAIL rst_ready: got %b, required 0", ifc.src_ready); else n_pass++;
        n_chk++; if (ifc.send_fifo_wrreq !== 1'b0) $display("FAIL rst_wrreq: got %b, required 0", ifc.send_fifo_wrreq); else n_pass++;
        n_chk++; if (ifc.send_fifo_data !== 512'd0) $display("FAIL rst_data: got %h, required 0", ifc.send_fifo_data); else n_pass++;
        n_chk++; if (ifc.done_valid !== 1'b0) $display("FAIL rst_done: got %b, required 0", ifc.done_valid); else n_pass++;
        n_chk++; if (ifc.done_core_id !== 2'd0) $display("FAIL rst_done_core: got %0d, required 0", ifc.done_core_id); else n_pass++;
        n_chk++; if (ifc.overflow_err !== 1'b0) $display("FAIL rst_ovf: got %b, required 0", ifc.overflow_err); else n_pass++;
        reset_n = 1'b1;
        #1;
        n_chk++; if (ifc.src_ready !== 1'b1) $display("FAIL rst_release_ready: got %b, required 1", ifc.src_ready); else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_single();
        int base, d0, t;
        bit ok;
        base = cap_q.size();
        d0 = done_cnt;
        ifc.send_fifo_wrusedw = 11'd0;
        send_beat(1'b1, 1'b1, pat(1), 2'd2, 32'h5);
        t = acc_cyc;
        wait_done(d0, ok);
        n_chk++; if (ok !== 1'b1) $display("FAIL single_done: done_valid not seen, required within 100 cycles"); else n_pass++;
        n_chk++; if (cap_q.size() - base != 2) $display("FAIL single_words: got %0d, required 2", cap_q.size() - base); else n_pass++;
        n_chk++; if (cap_at(base) !== hdr(2, 32'h5, 2'd2)) $display("FAIL single_hdr: got %h, required %h", cap_at(base), hdr(2, 32'h5, 2'd2)); else n_pass++;
        n_chk++; if (cap_at(base + 1) !== pat(1)) $display("FAIL single_payload: got %h, required %h", cap_at(base + 1), pat(1)); else n_pass++;
        n_chk++; if (done_core !== 2'd2) $display("FAIL single_done_core: got %0d, required 2", done_core); else n_pass++;
        n_chk++; if (capc_at(base) != t + 2) $display("FAIL single_hdr_lat: got edge %0d, required %0d", capc_at(base), t + 2); else n_pass++;
        n_chk++; if (capc_at(base + 1) != t + 3) $display("FAIL single_last_lat: got edge %0d, required %0d", capc_at(base + 1), t + 3); else n_pass++;
        n_chk++; if (done_cyc != t + 4) $display("FAIL single_done_lat: got edge %0d, required %0d", done_cyc, t + 4); else n_pass++;
    endtask

    task automatic test_backpressure();
        int base, d0;
        bit ok;
        base = cap_q.size();
        d0 = done_cnt;
        ifc.send_fifo_wrusedw = 11'd2045;
        for (int i = 0; i < 4; i++) send_beat(i == 0, i == 3, pat(10 + i), 2'd1, 32'h1234);
        repeat (10) @(negedge clk);
        n_chk++; if (ifc.src_ready !== 1'b0) $display("FAIL bp_ready_held: got %b, required 0", ifc.src_ready); else n_pass++;
        n_chk++; if (cap_q.size() != base) $display("FAIL bp_no_write_2045: got %0d writes, required 0", cap_q.size() - base); else n_pass++;
        ifc.send_fifo_wrusedw = 11'd2043;
        repeat (5) @(negedge clk);
        n_chk++; if (cap_q.size() != base) $display("FAIL bp_no_write_2043: got %0d writes, required 0", cap_q.size() - base); else n_pass++;
        ifc.send_fifo_wrusedw = 11'd2042;
        wait_done(d0, ok);
        ifc.send_fifo_wrusedw = 11'd0;
        n_chk++; if (ok !== 1'b1) $display("FAIL bp_done: done_valid not seen, required within 100 cycles"); else n_pass++;
        n_chk++; if (cap_q.size() - base != 5) $display("FAIL bp_words: got %0d, required 5", cap_q.size() - base); else n_pass++;
        n_chk++; if (cap_at(base) !== hdr(5, 32'h1234, 2'd1)) $display("FAIL bp_hdr: got %h, required %h", cap_at(base), hdr(5, 32'h1234, 2'd1)); else n_pass++;
        for (int i = 0; i < 4; i++) begin
            n_chk++;
            if (cap_at(base + 1 + i) !== pat(10 + i)) $display("FAIL bp_payload%0d: got %h, required %h", i, cap_at(base + 1 + i), pat(10 + i));
            else n_pass++;
        end
        n_chk++; if (capc_at(base + 4) - capc_at(base) != 4) $display("FAIL bp_gapless: span %0d edges, required 4", capc_at(base + 4) - capc_at(base)); else n_pass++;
        n_chk++; if (done_core !== 2'd1) $display("FAIL bp_done_core: got %0d, required 1", done_core); else n_pass++;
    endtask

    task automatic test_full_depth();
        int base, d0;
        bit ok;
        base = cap_q.size();
        d0 = done_cnt;
        for (int i = 0; i < DEPTH; i++) send_beat(i == 0, i == DEPTH - 1, pat(20 + i), 2'd3, 32'hD0);
        wait_done(d0, ok);
        n_chk++; if (ok !== 1'b1) $display("FAIL full_done: done_valid not seen, required within 100 cycles"); else n_pass++;
        n_chk++; if (cap_q.size() - base != DEPTH + 1) $display("FAIL full_words: got %0d, required %0d", cap_q.size() - base, DEPTH + 1); else n_pass++;
        n_chk++; if (cap_at(base) !== hdr(DEPTH + 1, 32'hD0, 2'd3)) $display("FAIL full_hdr: got %h, required %h", cap_at(base), hdr(DEPTH + 1, 32'hD0, 2'd3)); else n_pass++;
        n_chk++; if (cap_at(base + DEPTH) !== pat(20 + DEPTH - 1)) $display("FAIL full_last: got %h, required %h", cap_at(base + DEPTH), pat(20 + DEPTH - 1)); else n_pass++;
        n_chk++; if (ifc.overflow_err !== 1'b0) $display("FAIL full_no_ovf: got %b, required 0", ifc.overflow_err); else n_pass++;
    endtask

    task automatic test_overflow();
        int base, d0;
        bit ok;
        base = cap_q.size();
        d0 = done_cnt;
        for (int i = 0; i < DEPTH; i++) send_beat(i == 0, 1'b0, pat(30 + i), 2'd0, 32'hEE);
        n_chk++; if (ifc.overflow_err !== 1'b0) $display("FAIL ovf_at_depth: got %b, required 0", ifc.overflow_err); else n_pass++;
        send_beat(1'b0, 1'b0, pat(38), 2'd0, 32'hEE);
        n_chk++; if (ifc.overflow_err !== 1'b1) $display("FAIL ovf_set: got %b, required 1", ifc.overflow_err); else n_pass++;
        send_beat(1'b0, 1'b1, pat(39), 2'd0, 32'hEE);
        repeat (10) @(negedge clk);
        n_chk++; if (cap_q.size() != base) $display("FAIL ovf_no_write: got %0d writes, required 0", cap_q.size() - base); else n_pass++;
        n_chk++; if (done_cnt != d0) $display("FAIL ovf_no_done: got %0d done pulses, required 0", done_cnt - d0); else n_pass++;
        send_beat(1'b1, 1'b0, pat(45), 2'd3, 32'h77);
        send_beat(1'b0, 1'b1, pat(46), 2'd3, 32'h77);
        wait_done(d0, ok);
        n_chk++; if (ok !== 1'b1) $display("FAIL ovf_next_done: done_valid not seen, required within 100 cycles"); else n_pass++;
        n_chk++; if (cap_q.size() - base != 3) $display("FAIL ovf_next_words: got %0d, required 3", cap_q.size() - base); else n_pass++;
        n_chk++; if (cap_at(base) !== hdr(3, 32'h77, 2'd3)) $display("FAIL ovf_next_hdr: got %h, required %h", cap_at(base), hdr(3, 32'h77, 2'd3)); else n_pass++;
        n_chk++; if (cap_at(base + 1) !== pat(45)) $display("FAIL ovf_next_p0: got %h, required %h", cap_at(base + 1), pat(45)); else n_pass++;
        n_chk++; if (cap_at(base + 2) !== pat(46)) $display("FAIL ovf_next_p1: got %h, required %h", cap_at(base + 2), pat(46)); else n_pass++;
        n_chk++; if (done_core !== 2'd3) $display("FAIL ovf_next_core: got %0d, required 3", done_core); else n_pass++;
        n_chk++; if (ifc.overflow_err !== 1'b1) $display("FAIL ovf_sticky: got %b, required 1", ifc.overflow_err); else n_pass++;
    endtask

    task automatic test_restart();
        int base, d0;
        bit ok;
        base = cap_q.size();
        d0 = done_cnt;
        for (int i = 0; i < 3; i++) send_beat(i == 0, 1'b0, pat(40 + i), 2'd0, 32'hAA);
        send_beat(1'b1, 1'b0, pat(50), 2'd1, 32'hBB);
        send_beat(1'b0, 1'b1, pat(51), 2'd1, 32'hBB);
        wait_done(d0, ok);
        n_chk++; if (ok !== 1'b1) $display("FAIL restart_done: done_valid not seen, required within 100 cycles"); else n_pass++;
        n_chk++; if (cap_q.size() - base != 3) $display("FAIL restart_words: got %0d, required 3", cap_q.size() - base); else n_pass++;
        n_chk++; if (cap_at(base) !== hdr(3, 32'hBB, 2'd1)) $display("FAIL restart_hdr: got %h, required %h", cap_at(base), hdr(3, 32'hBB, 2'd1)); else n_pass++;
        n_chk++; if (cap_at(base + 1) !== pat(50)) $display("FAIL restart_p0: got %h, required %h", cap_at(base + 1), pat(50)); else n_pass++;
        n_chk++; if (cap_at(base + 2) !== pat(51)) $display("FAIL restart_p1: got %h, required %h", cap_at(base + 2), pat(51)); else n_pass++;
        n_chk++; if (done_core !== 2'd1) $display("FAIL restart_core: got %0d, required 1", done_core); else n_pass++;
    endtask

    task automatic test_reset_drain();
        int base, d0, n, n_before;
        bit ok;
        base = cap_q.size();
        d0 = done_cnt;
        for (int i = 0; i < 4; i++) send_beat(i == 0, i == 3, pat(60 + i), 2'd2, 32'h42);
        n = 0;
        while (cap_q.size() - base < 2 && n < 50) begin
            @(negedge clk);
            n++;
        end
        #2;
        reset_n = 1'b0;
        #1;
        n_chk++; if (ifc.send_fifo_wrreq !== 1'b0) $display("FAIL rd_wrreq_async: got %b, required 0", ifc.send_fifo_wrreq); else n_pass++;
        n_chk++; if (ifc.send_fifo_data !== 512'd0) $display("FAIL rd_data: got %h, required 0", ifc.send_fifo_data); else n_pass++;
        n_chk++; if (ifc.src_ready !== 1'b0) $display("FAIL rd_ready: got %b, required 0", ifc.src_ready); else n_pass++;
        n_chk++; if (ifc.overflow_err !== 1'b0) $display("FAIL rd_ovf_cleared: got %b, required 0", ifc.overflow_err); else n_pass++;
        n_chk++; if (ifc.done_core_id !== 2'd0) $display("FAIL rd_done_core: got %0d, required 0", ifc.done_core_id); else n_pass++;
        n_before = cap_q.size();
        n_chk++; if (n_before - base >= 5) $display("FAIL rd_abandoned: got %0d words, required fewer than 5", n_before - base); else n_pass++;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (5) @(negedge clk);
        n_chk++; if (cap_q.size() != n_before) $display("FAIL rd_no_write_after: got %0d extra writes, required 0", cap_q.size() - n_before); else n_pass++;
        n_chk++; if (done_cnt != d0) $display("FAIL rd_no_done: got %0d done pulses, required 0", done_cnt - d0); else n_pass++;
        base = cap_q.size();
        send_beat(1'b1, 1'b1, pat(70), 2'd1, 32'h9);
        wait_done(d0, ok);
        n_chk++; if (ok !== 1'b1) $display("FAIL rd_recover_done: done_valid not seen, required within 100 cycles"); else n_pass++;
        n_chk++; if (cap_q.size() - base != 2) $display("FAIL rd_recover_words: got %0d, required 2", cap_q.size() - base); else n_pass++;
        n_chk++; if (cap_at(base) !== hdr(2, 32'h9, 2'd1)) $display("FAIL rd_recover_hdr: got %h, required %h", cap_at(base), hdr(2, 32'h9, 2'd1)); else n_pass++;
        n_chk++; if (cap_at(base + 1) !== pat(70)) $display("FAIL rd_recover_payload: got %h, required %h", cap_at(base + 1), pat(70)); else n_pass++;
    endtask

    initial begin
        reset_n               = 1'b0;
        ifc.src_valid         = 1'b0;
        ifc.src_sop           = 1'b0;
        ifc.src_eop           = 1'b0;
        ifc.src_data          = '0;
        ifc.src_core_id       = '0;
        ifc.src_data_id       = '0;
        ifc.send_fifo_wrusedw = '0;
        @(negedge clk);
        test_reset();
        test_single();
        test_backpressure();
        test_full_depth();
        test_overflow();
        test_restart();
        test_reset_drain();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
